// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and add/sub control encodings
// Purpose: state type for the modular-reduction controller and the
//          add/sub unit control values.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } mod_state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/add_sub.sv
// rtl/add_sub.sv - adder/subtractor built from mux_not and adder
// Purpose: ctrl=ADD gives a+b, ctrl=SUB gives a+~b+1 (a-b); in subtract
//          mode cout=1 means a >= b (no borrow).
// Ports:   a, b - operands
//          ctrl - ADD/SUB select, also used as carry in
//          sum  - result
//          cout - carry out
module add_sub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_mux;

  mux_not #(.WIDTH(WIDTH)) u_mux_not (
    .ctrl_i (ctrl),
    .d_i    (b),
    .y_o    (b_mux)
  );

  adder #(.WIDTH(WIDTH)) u_adder (
    .a_i    (a),
    .b_i    (b_mux),
    .cin_i  (ctrl),
    .sum_o  (sum),
    .cout_o (cout)
  );

endmodule

// File: rtl/adder.sv
// rtl/adder.sv - ripple-free behavioural adder with carry in/out
// Purpose: sum_o/cout_o = a_i + b_i + cin_i.
// Ports:   a_i, b_i - operands
//          cin_i    - carry in
//          sum_o    - low WIDTH bits of the sum
//          cout_o   - carry out
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/mux_not.sv
// rtl/mux_not.sv - conditional bitwise inverter
// Purpose: passes d_i through, or its one's complement when ctrl_i=1.
// Ports:   ctrl_i - invert select
//          d_i    - operand
//          y_o    - d_i or ~d_i
module mux_not #(
  parameter int WIDTH = 8
) (
  input  logic             ctrl_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = ctrl_i ? ~d_i : d_i;

endmodule

// File: rtl/mod_reduce_ctrl.sv
// rtl/mod_reduce_ctrl.sv - restoring shift-and-subtract a mod m / a div m
// Purpose: multi-cycle unsigned remainder and quotient, one dividend bit
//          per cycle through a single shared add/sub unit in subtract mode.
// Ports:   clk, rst_n - clock, asynchronous active-low reset
//          start      - request, sampled only in IDLE
//          a, m       - dividend and modulus, captured on accepted start
//          busy       - high in every state except IDLE
//          done       - one-cycle result-valid strobe
//          err        - modulus was zero; held until next accepted start
//          rem, quo   - remainder and quotient; held until next accepted start
module mod_reduce_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] quo
);

  localparam int CW = $clog2(WIDTH);

  mod_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   d;
  logic             cout;
  logic             unused_msb;

  // R < m after every step, so the shifted-out MSB of R is always zero.
  assign t          = {r_q[WIDTH-1:0], a_q[cnt_q]};
  assign unused_msb = r_q[WIDTH];

  add_sub #(.WIDTH(WIDTH + 1)) u_add_sub (
    .a    (t),
    .b    ({1'b0, m_q}),
    .ctrl (SUB),
    .sum  (d),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    r_d     = r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = '0;
          quo_d = '0;
          if (m != '0) begin
            a_d     = a;
            m_d     = m;
            r_d     = '0;
            cnt_d   = CW'(WIDTH - 1);
            err_d   = 1'b0;
            state_d = ITER;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ITER: begin
        // cout=1 means no borrow: T >= m, keep the difference.
        r_d          = cout ? d : t;
        quo_d[cnt_q] = cout;
        if (cnt_q == '0) begin
          // Register the remainder on the last step so it is valid with done.
          rem_d   = r_d[WIDTH-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign rem  = rem_q;
  assign quo  = quo_q;

endmodule

// File: tb/tb_mod_reduce_ctrl.sv
// tb/tb_mod_reduce_ctrl.sv - self-checking bench for mod_reduce_ctrl
module tb_mod_reduce_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] m;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] rem;
  logic [W-1:0] quo;

  int tests_run = 0;
  int fails     = 0;

  mod_reduce_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rem   (rem),
    .quo   (quo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and follow it until busy drops. lat = samples after the
  // accepting edge before done is first seen (-1 if never).
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] mv,
                       output int lat, output int busy_n, output int done_n,
                       output logic [W-1:0] r, output logic [W-1:0] q,
                       output logic e);
    @(negedge clk);
    start = 1'b1; a = av; m = mv;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); m = W'($urandom);
    lat = -1; busy_n = 0; done_n = 0; r = '0; q = '0; e = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; r = rem; q = quo; e = err;
        end
      end
      if (!busy) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy, done, err, rem, quo} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%0b done=%0b err=%0b rem=%0d quo=%0d want all 0",
               busy, done, err, rem, quo);
    end
  endtask

  // Checks one operation against plain integer division.
  task automatic check_op(input string name, input logic [W-1:0] av, input logic [W-1:0] mv);
    int lat, bn, dn;
    logic [W-1:0] r, q;
    logic e;
    int exp_lat, exp_busy;
    logic [W-1:0] exp_r, exp_q;
    logic exp_e;
    do_op(av, mv, lat, bn, dn, r, q, e);
    if (mv == 0) begin
      exp_lat = 0; exp_busy = 1; exp_r = 0; exp_q = 0; exp_e = 1'b1;
    end else begin
      exp_lat = W; exp_busy = W + 1; exp_r = av % mv; exp_q = av / mv; exp_e = 1'b0;
    end
    tests_run++;
    if (lat !== exp_lat || dn !== 1 || bn !== exp_busy) begin
      fails++;
      $display("FAIL %s_timing a=%0d m=%0d got lat=%0d dones=%0d busy_cycles=%0d want %0d 1 %0d",
               name, av, mv, lat, dn, bn, exp_lat, exp_busy);
    end
    tests_run++;
    if (r !== exp_r || q !== exp_q || e !== exp_e) begin
      fails++;
      $display("FAIL %s_result a=%0d m=%0d got rem=%0d quo=%0d err=%0b want rem=%0d quo=%0d err=%0b",
               name, av, mv, r, q, e, exp_r, exp_q, exp_e);
    end
    tests_run++;
    if (rem !== exp_r || quo !== exp_q || err !== exp_e || done !== 1'b0) begin
      fails++;
      $display("FAIL %s_hold got rem=%0d quo=%0d err=%0b done=%0b want rem=%0d quo=%0d err=%0b done=0",
               name, rem, quo, err, done, exp_r, exp_q, exp_e);
    end
  endtask

  task automatic test_basic();
    check_op("basic", 8'd200, 8'd7);
  endtask

  task automatic test_small();
    check_op("small", 8'd5, 8'd9);
    check_op("equal", 8'hAB, 8'hAB);
  endtask

  task automatic test_extremes();
    check_op("m_one", 8'd255, 8'd1);
    check_op("max_max", 8'd255, 8'd255);
    check_op("below_max", 8'd254, 8'd255);
  endtask

  task automatic test_div_zero();
    check_op("pre_zero", 8'd200, 8'd7);
    check_op("div_zero", 8'd123, 8'd0);
    check_op("after_zero", 8'd77, 8'd10);
  endtask

  task automatic test_handshake();
    logic seen;
    @(negedge clk);
    start = 1'b1; a = 8'd200; m = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; a = 8'd13; m = 8'd3;
      end else if (k == 9) begin
        start = 1'b1; a = 8'd99; m = 8'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 8) begin
        tests_run++;
        if (done !== 1'b1 || rem !== 8'd4 || quo !== 8'd28) begin
          fails++;
          $display("FAIL hs_result got done=%0b rem=%0d quo=%0d want 1 4 28", done, rem, quo);
        end
      end
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || rem !== 8'd4 || quo !== 8'd28 || err !== 1'b0) begin
      fails++;
      $display("FAIL hs_ignored got busy=%0b done=%0b rem=%0d quo=%0d err=%0b want 0 0 4 28 0",
               busy, done, rem, quo, err);
    end
    @(negedge clk);
    start = 1'b1; a = 8'd100; m = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL hs_accept got busy=%0b want 1", busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    tests_run++;
    if (!seen || rem !== 8'd1 || quo !== 8'd11) begin
      fails++;
      $display("FAIL hs_second got done_seen=%0b rem=%0d quo=%0d want 1 1 11", seen, rem, quo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    start = 1'b1; a = 8'd200; m = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, err, rem, quo} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs got busy=%0b done=%0b err=%0b rem=%0d quo=%0d want all 0",
               busy, done, err, rem, quo);
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_no_done got dones=%0d busy=%0b want 0 0", dones, busy);
    end
    check_op("after_reset", 8'd200, 8'd7);
  endtask

  task automatic test_random();
    logic [W-1:0] av, mv;
    for (int i = 0; i < 24; i++) begin
      av = W'($urandom);
      mv = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
      check_op("random", av, mv);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; m = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_small();
    test_extremes();
    test_div_zero();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
